video_rect_blend_core: RTL and testbench

//  Daisy-chain video core that alpha-blends one programmable solid-colour rectangle onto the pixel stream.
//  It sits between the pacman sprite core and the rgb2gray core on sys_clk and uses the same src/snk vld/rdy + vga_fc_t stream.
//  It is configured over a write-only Avalon CSR. Pixels outside the rectangle, or all pixels when disabled, pass through unchanged.

---
 rtl/video_rect_blend_pkg.sv | 49 ++++
 rtl/video_rect_blend_csr.sv | 59 +++++
 rtl/video_rect_blend_core.sv | 126 ++++++++++++
 tb/tb_video_rect_blend_core.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_rect_blend_pkg.sv
// Shared types for the rectangle blend core: stream frame counters, CSR map,
// rectangle configuration and the per-channel blend arithmetic.
package video_rect_blend_pkg;

    // Frame counter widths (same values as vga.svh, kept here so the slice is self-contained).
    localparam int H_SIZE = 10;
    localparam int V_SIZE = 10;

    typedef struct packed {
        logic              frame_start;
        logic [H_SIZE-1:0] hc;
        logic [V_SIZE-1:0] vc;
    } vga_fc_t;

    localparam logic [2:0] CSR_CTRL   = 3'd0;
    localparam logic [2:0] CSR_XRANGE = 3'd1;
    localparam logic [2:0] CSR_YRANGE = 3'd2;
    localparam logic [2:0] CSR_COLOR  = 3'd3;
    localparam logic [2:0] CSR_ALPHA  = 3'd4;

    localparam int         CFG_RGB_W = 12;
    localparam logic [4:0] ALPHA_ONE = 5'd16;

    typedef struct packed {
        logic                 enable;
        logic [15:0]          x0;
        logic [15:0]          x1;
        logic [15:0]          y0;
        logic [15:0]          y1;
        logic [CFG_RGB_W-1:0] color;
        logic [4:0]           alpha;
    } rect_cfg_t;

    // (a*c + (16-a)*p + 8) >> 4 for channels up to 8 bits, result truncated to w bits.
    function automatic logic [7:0] blend_ch(input logic [4:0] a, input logic [7:0] c,
                                            input logic [7:0] p, input int w);
        logic [12:0] acc;
        logic [7:0]  res;
        acc = 13'(a) * 13'(c) + 13'(ALPHA_ONE - a) * 13'(p) + 13'd8;
        res = 8'(acc >> 4);
        for (int i = 0; i < 8; i++) begin
            if (i >= w) begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/video_rect_blend_csr.sv
// Write-only CSR block: pending register set written over Avalon, copied into
// the active set on the frame-origin beat.
module video_rect_blend_csr
    import video_rect_blend_pkg::*;
#(
    parameter int RGB_SIZE = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        shadow_load,
    output rect_cfg_t   cfg
);

    rect_cfg_t pend_q, pend_d;
    rect_cfg_t act_q, act_d;

    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        // Active takes the pending value as it stood before any write in this cycle.
        if (shadow_load) begin
            act_d = pend_q;
        end
        if (avs_write) begin
            case (avs_address)
                CSR_CTRL: pend_d.enable = avs_writedata[0];
                CSR_XRANGE: begin
                    pend_d.x0 = avs_writedata[15:0];
                    pend_d.x1 = avs_writedata[31:16];
                end
                CSR_YRANGE: begin
                    pend_d.y0 = avs_writedata[15:0];
                    pend_d.y1 = avs_writedata[31:16];
                end
                CSR_COLOR: pend_d.color = CFG_RGB_W'(avs_writedata[RGB_SIZE-1:0]);
                CSR_ALPHA: pend_d.alpha = (avs_writedata[4:0] > ALPHA_ONE) ? ALPHA_ONE
                                                                           : avs_writedata[4:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
        end
    end

    // The origin beat itself already belongs to the new frame, so it sees the incoming set.
    assign cfg = shadow_load ? pend_q : act_q;

endmodule

// File: rtl/video_rect_blend_core.sv
// Daisy-chain stream core: alpha-blends one solid rectangle onto the pixel
// stream through a 2-stage vld/rdy pipeline.
module video_rect_blend_core
    import video_rect_blend_pkg::*;
#(
    parameter int RSIZE    = 4,
    parameter int GSIZE    = 4,
    parameter int BSIZE    = 4,
    parameter int RGB_SIZE = RSIZE + GSIZE + BSIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          avs_address,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    input  vga_fc_t             src_fc,
    input  logic                src_vld,
    input  logic [RGB_SIZE-1:0] src_rgb,
    output logic                src_rdy,
    output vga_fc_t             snk_fc,
    output logic                snk_vld,
    output logic [RGB_SIZE-1:0] snk_rgb,
    input  logic                snk_rdy
);

    localparam int B_LO = 0;
    localparam int G_LO = BSIZE;
    localparam int R_LO = BSIZE + GSIZE;

    logic                s1_vld_q, s1_vld_d;
    logic [RGB_SIZE-1:0] s1_rgb_q, s1_rgb_d;
    vga_fc_t             s1_fc_q, s1_fc_d;
    logic                s1_hit_q, s1_hit_d;
    logic [RGB_SIZE-1:0] s1_color_q, s1_color_d;
    logic [4:0]          s1_alpha_q, s1_alpha_d;
    logic                s2_vld_q, s2_vld_d;
    logic [RGB_SIZE-1:0] s2_rgb_q, s2_rgb_d;
    vga_fc_t             s2_fc_q, s2_fc_d;

    logic                adv;
    logic                origin_beat;
    logic                hit;
    logic [RGB_SIZE-1:0] blend_rgb;
    rect_cfg_t           cfg;

    assign adv         = ~s2_vld_q | snk_rdy;
    assign src_rdy     = adv;
    assign origin_beat = src_vld && adv && (src_fc.hc == '0) && (src_fc.vc == '0);

    video_rect_blend_csr #(
        .RGB_SIZE (RGB_SIZE)
    ) u_csr (
        .clk           (clk),
        .rst           (rst),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .shadow_load   (origin_beat),
        .cfg           (cfg)
    );

    // Inclusive unsigned bounds; x0>x1 or y0>y1 can never match.
    assign hit = cfg.enable
              && (16'(src_fc.hc) >= cfg.x0) && (16'(src_fc.hc) <= cfg.x1)
              && (16'(src_fc.vc) >= cfg.y0) && (16'(src_fc.vc) <= cfg.y1);

    assign blend_rgb[R_LO +: RSIZE] = RSIZE'(blend_ch(s1_alpha_q, 8'(s1_color_q[R_LO +: RSIZE]),
                                                      8'(s1_rgb_q[R_LO +: RSIZE]), RSIZE));
    assign blend_rgb[G_LO +: GSIZE] = GSIZE'(blend_ch(s1_alpha_q, 8'(s1_color_q[G_LO +: GSIZE]),
                                                      8'(s1_rgb_q[G_LO +: GSIZE]), GSIZE));
    assign blend_rgb[B_LO +: BSIZE] = BSIZE'(blend_ch(s1_alpha_q, 8'(s1_color_q[B_LO +: BSIZE]),
                                                      8'(s1_rgb_q[B_LO +: BSIZE]), BSIZE));

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_rgb_d   = s1_rgb_q;
        s1_fc_d    = s1_fc_q;
        s1_hit_d   = s1_hit_q;
        s1_color_d = s1_color_q;
        s1_alpha_d = s1_alpha_q;
        s2_vld_d   = s2_vld_q;
        s2_rgb_d   = s2_rgb_q;
        s2_fc_d    = s2_fc_q;
        // Colour and alpha travel with the pixel so a frame-origin reload cannot touch beats in flight.
        if (adv) begin
            s1_vld_d   = src_vld;
            s1_rgb_d   = src_rgb;
            s1_fc_d    = src_fc;
            s1_hit_d   = hit;
            s1_color_d = RGB_SIZE'(cfg.color);
            s1_alpha_d = cfg.alpha;
            s2_vld_d   = s1_vld_q;
            s2_rgb_d   = s1_hit_q ? blend_rgb : s1_rgb_q;
            s2_fc_d    = s1_fc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q   <= 1'b0;
            s1_rgb_q   <= '0;
            s1_fc_q    <= '0;
            s1_hit_q   <= 1'b0;
            s1_color_q <= '0;
            s1_alpha_q <= '0;
            s2_vld_q   <= 1'b0;
            s2_rgb_q   <= '0;
            s2_fc_q    <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_rgb_q   <= s1_rgb_d;
            s1_fc_q    <= s1_fc_d;
            s1_hit_q   <= s1_hit_d;
            s1_color_q <= s1_color_d;
            s1_alpha_q <= s1_alpha_d;
            s2_vld_q   <= s2_vld_d;
            s2_rgb_q   <= s2_rgb_d;
            s2_fc_q    <= s2_fc_d;
        end
    end

    assign snk_vld = s2_vld_q;
    assign snk_rgb = s2_rgb_q;
    assign snk_fc  = s2_fc_q;

endmodule

// File: tb/tb_video_rect_blend_core.sv
// Scoreboard bench for video_rect_blend_core: a CSR/shadow model predicts each
// pixel at acceptance; outputs are popped and compared as they leave.
module tb_video_rect_blend_core;
    import video_rect_blend_pkg::*;

    localparam int FW = 32;
    localparam int FH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    vga_fc_t     src_fc = '0;
    logic        src_vld = 1'b0;
    logic [11:0] src_rgb = '0;
    logic        src_rdy;
    vga_fc_t     snk_fc;
    logic        snk_vld;
    logic [11:0] snk_rgb;
    logic        snk_rdy = 1'b1;

    video_rect_blend_core dut (
        .clk           (clk),
        .rst           (rst),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .src_fc        (src_fc),
        .src_vld       (src_vld),
        .src_rgb       (src_rgb),
        .src_rdy       (src_rdy),
        .snk_fc        (snk_fc),
        .snk_vld       (snk_vld),
        .snk_rgb       (snk_rgb),
        .snk_rdy       (snk_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic [31:0] fc;
        int          cyc;
    } exp_t;

    typedef struct {
        bit en;
        int x0, x1, y0, y1;
        int color;
        int alpha;
    } mcfg_t;

    exp_t  sbq[$];
    mcfg_t m_pen = '{default: 0};
    mcfg_t m_act = '{default: 0};
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_pix(input mcfg_t c, input int hc, input int vc,
                                              input logic [11:0] p);
        logic [11:0] r;
        int a, cc, pp;
        if (!(c.en && hc >= c.x0 && hc <= c.x1 && vc >= c.y0 && vc <= c.y1)) return p;
        a = c.alpha;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            cc = (c.color >> (4 * k)) & 15;
            pp = (int'(p) >> (4 * k)) & 15;
            r[4*k +: 4] = 4'((a * cc + (16 - a) * pp + 8) >> 4);
        end
        return r;
    endfunction

    task automatic m_write(input int addr, input logic [31:0] d);
        case (addr)
            0: m_pen.en = d[0];
            1: begin m_pen.x0 = int'(d[15:0]); m_pen.x1 = int'(d[31:16]); end
            2: begin m_pen.y0 = int'(d[15:0]); m_pen.y1 = int'(d[31:16]); end
            3: m_pen.color = int'(d[11:0]);
            4: m_pen.alpha = (d[4:0] > 5'd16) ? 16 : int'(d[4:0]);
            default: ;
        endcase
    endtask

    // Output side: one compare set per beat leaving the core.
    always @(negedge clk) begin
        if (rst && snk_vld && snk_rdy) begin
            if (sbq.size() == 0) begin
                check_eq("sb_underflow", 32'(sbq.size()), 32'd1);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                $display("beat hc=%0d vc=%0d rgb=%h want=%h", snk_fc.hc, snk_fc.vc, snk_rgb, e.rgb);
                check_eq("rgb", 32'(snk_rgb), 32'(e.rgb));
                check_eq("fc", 32'(snk_fc), e.fc);
                if (chk_lat) check_eq("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
    end

    task automatic csr_wr(input int addr, input logic [31:0] data);
        src_vld       = 1'b0;
        avs_address   = 3'(addr);
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        m_write(addr, data);
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        $display("csr addr=%0d data=%h", addr, data);
    endtask

    task automatic send_beat(input int hc, input int vc, input logic [11:0] p,
                             input bit wr, input int addr, input logic [31:0] data);
        bit      acc;
        int      tries;
        vga_fc_t f;
        exp_t    e;
        f.frame_start = (hc == 0 && vc == 0);
        f.hc          = H_SIZE'(hc);
        f.vc          = V_SIZE'(vc);
        src_fc        = f;
        src_rgb       = p;
        src_vld       = 1'b1;
        avs_write     = wr;
        avs_address   = 3'(addr);
        avs_writedata = data;
        acc   = 1'b0;
        tries = 0;
        while (!acc) begin
            @(negedge clk);
            acc = src_rdy;
            if (acc) begin
                if (hc == 0 && vc == 0) m_act = m_pen;
                e.rgb = model_pix(m_act, hc, vc, p);
                e.fc  = 32'(f);
                e.cyc = cyc;
                sbq.push_back(e);
            end
            if (avs_write) m_write(addr, data);
            @(posedge clk);
            #1;
            avs_write = 1'b0;
            tries++;
            if (!acc && tries > 20) begin
                check_eq("accept_timeout", 32'(tries), 32'd0);
                acc = 1'b1;
            end
        end
    endtask

    // Downstream back-pressure for 5 cycles while the upstream keeps offering a stale beat.
    task automatic stall5();
        logic [11:0] r0;
        logic [31:0] f0;
        snk_rdy = 1'b0;
        r0 = '0;
        f0 = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                r0 = snk_rgb;
                f0 = 32'(snk_fc);
            end
            check_eq("stall_src_rdy", 32'(src_rdy), 32'd0);
            check_eq("stall_vld", 32'(snk_vld), 32'd1);
            check_eq("stall_rgb", 32'(snk_rgb), 32'(r0));
            check_eq("stall_fc", 32'(snk_fc), f0);
        end
        @(posedge clk);
        #1;
        snk_rdy = 1'b1;
    endtask

    task automatic mid_reset();
        src_vld = 1'b0;
        rst     = 1'b0;
        #1;
        check_eq("mid_rst_vld", 32'(snk_vld), 32'd0);
        check_eq("mid_rst_rgb", 32'(snk_rgb), 32'd0);
        sbq.delete();
        m_pen = '{default: 0};
        m_act = '{default: 0};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        // Reprogram a rectangle; it must stay invisible until the next frame origin.
        csr_wr(1, {16'd20, 16'd10});
        csr_wr(2, {16'd6, 16'd5});
        csr_wr(3, 32'h00F);
        csr_wr(4, 32'd16);
        csr_wr(0, 32'd1);
    endtask

    task automatic run_frame(input bit rnd, input logic [11:0] fixed, input int stall_idx,
                             input int rst_idx, input int wr_idx, input int wr_addr,
                             input logic [31:0] wr_data);
        int          idx;
        logic [11:0] p;
        for (int vc = 0; vc < FH; vc++) begin
            for (int hc = 0; hc < FW; hc++) begin
                idx = vc * FW + hc;
                p   = rnd ? 12'($urandom) : fixed;
                send_beat(hc, vc, p, idx == wr_idx, wr_addr, wr_data);
                if (idx == stall_idx) stall5();
                if (idx == rst_idx) mid_reset();
            end
        end
        src_vld = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_snk_vld", 32'(snk_vld), 32'd0);
        check_eq("rst_snk_rgb", 32'(snk_rgb), 32'd0);
        check_eq("rst_snk_fc", 32'(snk_fc), 32'd0);
        check_eq("rst_src_rdy", 32'(src_rdy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Passthrough with untouched CSRs, latency checked.
        chk_lat = 1'b1;
        run_frame(1'b1, 12'h000, -1, -1, -1, 0, 0);
        chk_lat = 1'b0;

        // Opaque rectangle.
        csr_wr(1, {16'd20, 16'd10});
        csr_wr(2, {16'd6, 16'd5});
        csr_wr(3, 32'h00F);
        csr_wr(4, 32'd16);
        csr_wr(0, 32'd1);
        run_frame(1'b0, 12'hF00, -1, -1, -1, 0, 0);

        // Half, zero and saturated alpha.
        csr_wr(4, 32'd8);
        run_frame(1'b0, 12'hF00, -1, -1, -1, 0, 0);
        csr_wr(4, 32'd0);
        run_frame(1'b0, 12'hF00, -1, -1, -1, 0, 0);
        csr_wr(4, 32'd20);
        run_frame(1'b1, 12'h000, -1, -1, -1, 0, 0);

        // Inverted x range is an empty rectangle.
        csr_wr(1, {16'd10, 16'd20});
        run_frame(1'b0, 12'hF00, -1, -1, -1, 0, 0);
        csr_wr(1, {16'd20, 16'd10});
        csr_wr(4, 32'd16);

        // Back-pressure mid-line.
        run_frame(1'b1, 12'h000, 40, -1, -1, 0, 0);

        // COLOR written mid-frame, then again on the origin beat.
        run_frame(1'b0, 12'hF00, -1, -1, 100, 3, 32'h0F0);
        run_frame(1'b0, 12'hF00, -1, -1, 0, 3, 32'h123);
        run_frame(1'b0, 12'hF00, -1, -1, -1, 0, 0);

        // Reset mid-line, then passthrough until the following origin.
        run_frame(1'b0, 12'hF00, -1, 50, -1, 0, 0);
        run_frame(1'b0, 12'hF00, -1, -1, -1, 0, 0);

        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
        check_eq("drain", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
